pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, the width of the program counter and branch target.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, the PC value loaded on reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_alu_result  input  32  ALU result whose flags are to be captured.
REQ-006 SHALL have port in_flag_we  input  1  capture flags from in_alu_result this cycle.
REQ-007 SHALL have port in_ctrl_take  input  1  branch/jump taken decision, computed from out_neg/out_zero.
REQ-008 SHALL have port in_target  input  PC_WIDTH  redirect address, used when in_ctrl_take=1.
REQ-009 SHALL have port in_stall  input  1  hold the PC; the fetch is not consumed.
REQ-010 SHALL have port in_halt  input  1  stop sequencing permanently until reset.
REQ-011 SHALL have port out_pc  output  PC_WIDTH  current fetch address, registered.
REQ-012 SHALL have port out_neg  output  1  registered negative flag.
REQ-013 SHALL have port out_zero  output  1  registered zero flag.
REQ-014 SHALL have port out_fetch_valid  output  1  out_pc is a valid fetch this cycle.
REQ-015 SHALL have port out_redirect  output  1  one-cycle pulse: a redirect was taken, so the downstream stage flushes.
REQ-016 SHALL have port out_halted  output  1  the block is in the HALT state.

Function
REQ-017 SHALL implement the FSM states BOOT, RUN, BUBBLE and HALT.
REQ-018 BOOT SHALL drive out_fetch_valid=0 and SHALL go unconditionally to RUN on the next cycle, with out_pc=RESET_VECTOR.
REQ-019 RUN SHALL drive out_fetch_valid=1 and SHALL evaluate its inputs in priority order in_halt > in_ctrl_take > in_stall > increment.
REQ-020 RUN with in_halt=1 SHALL enter HALT with out_pc unchanged.
REQ-021 RUN with in_ctrl_take=1 SHALL load out_pc=in_target, pulse out_redirect=1 for exactly one cycle (the cycle after the take) and enter BUBBLE; the take overrides in_stall.
REQ-022 RUN with in_stall=1 SHALL hold out_pc and stay in RUN.
REQ-023 RUN with no condition active SHALL set out_pc=out_pc+1, modulo 2^PC_WIDTH; all-ones SHALL wrap to 0.
REQ-024 BUBBLE SHALL drive out_fetch_valid=0 and hold out_pc, ignore in_ctrl_take and in_stall, and go to RUN, or to HALT if in_halt=1.
REQ-025 HALT SHALL drive out_fetch_valid=0 and out_halted=1, hold out_pc, ignore all inputs and exit only on reset.
REQ-026 Flag capture SHALL occur in all states except HALT when in_flag_we=1: out_zero <= (in_alu_result==0), out_neg <= in_alu_result[31].
REQ-027 A simultaneous in_flag_we and in_ctrl_take SHALL use the pre-update flags for that take, with the new flags visible the next cycle.
REQ-028 in_stall SHALL NOT block flag capture.

Reset
REQ-029 Asserting rst SHALL immediately force the following, independent of clk: state=BOOT, out_pc=RESET_VECTOR, out_neg=0, out_zero=0, out_fetch_valid=0, out_redirect=0, out_halted=0.
REQ-030 Reset asserted mid-redirect or mid-halt SHALL discard the pending state entirely.
REQ-031 The first valid fetch SHALL be RESET_VECTOR, one cycle after rst deasserts.

Structure
REQ-032 The FSM state encoding, PC_WIDTH default and RESET_VECTOR default SHALL reside in a shared cpu package.
REQ-033 The flag register SHALL be the one natural sub-module, named flag_reg, with inputs clk, rst, we and result and outputs neg and zero.
REQ-034 The branch decision SHALL remain external; this block SHALL only consume in_ctrl_take.

Verification
REQ-035 Reset release with no stimulus -> out_fetch_valid=0 for 1 cycle, then out_pc=0,1,2,3 on consecutive cycles.
REQ-036 Taken branch at pc=5 with in_target=0x40 -> next out_pc=0x40 and out_redirect=1 for 1 cycle, then a BUBBLE with fetch_valid=0, then 0x40 valid and then 0x41.
REQ-037 Flags: in_alu_result=0x80000000 with we -> neg=1, zero=0; 0 with we -> neg=0, zero=1; take asserted in the same cycle as a write uses the old flags.
REQ-038 Stall for 3 cycles at pc=7, then release -> pc stays at 7 for 3 cycles, then 8; in_ctrl_take during the stall redirects immediately.
REQ-039 Wrap and halt: pc=0xFFFFFFFF increments to 0; in_halt and in_ctrl_take asserted together -> HALT, pc held, out_halted=1 until rst.
REQ-040 rst asserted asynchronously during BUBBLE -> outputs immediately take their reset values and the sequence restarts from RESET_VECTOR.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: state encoding and
// default widths/vectors used by the top and its flag register.
package pc_sequencer_pkg;

    localparam int          PC_WIDTH_DEF     = 32;
    localparam int          ALU_WIDTH        = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2,
        ST_HALT   = 2'd3
    } seq_state_t;

    // Only RUN presents a consumable fetch address.
    function automatic logic is_fetch_state(seq_state_t s);
        return (s == ST_RUN);
    endfunction

endpackage

// File: rtl/pc_sequencer_flag_reg.sv
// Negative/zero flag register captured from an ALU result on write enable.
module flag_reg
    import pc_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [ALU_WIDTH-1:0] result,
    output logic                 neg,
    output logic                 zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg  <= 1'b0;
            zero <= 1'b0;
        end else if (we) begin
            neg  <= result[ALU_WIDTH-1];
            zero <= (result == '0);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: boot, linear increment, stall, taken-redirect with
// a one-cycle bubble, and a sticky halt; also owns the neg/zero flag register.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                PC_WIDTH     = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         in_alu_result,
    input  logic                in_flag_we,
    input  logic                in_ctrl_take,
    input  logic [PC_WIDTH-1:0] in_target,
    input  logic                in_stall,
    input  logic                in_halt,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic                out_neg,
    output logic                out_zero,
    output logic                out_fetch_valid,
    output logic                out_redirect,
    output logic                out_halted
);

    seq_state_t state;
    logic       flag_we;

    // Flags freeze once halted; stall does not gate capture.
    assign flag_we = in_flag_we && (state != ST_HALT);

    flag_reg u_flag_reg (
        .clk    (clk),
        .rst    (rst),
        .we     (flag_we),
        .result (in_alu_result),
        .neg    (out_neg),
        .zero   (out_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_BOOT;
            out_pc          <= RESET_VECTOR;
            out_fetch_valid <= 1'b0;
            out_redirect    <= 1'b0;
            out_halted      <= 1'b0;
        end else begin
            out_redirect <= 1'b0;
            case (state)
                ST_BOOT: begin
                    state           <= ST_RUN;
                    out_fetch_valid <= is_fetch_state(ST_RUN);
                end
                ST_RUN: begin
                    if (in_halt) begin
                        state           <= ST_HALT;
                        out_fetch_valid <= is_fetch_state(ST_HALT);
                        out_halted      <= 1'b1;
                    end else if (in_ctrl_take) begin
                        state           <= ST_BUBBLE;
                        out_pc          <= in_target;
                        out_redirect    <= 1'b1;
                        out_fetch_valid <= is_fetch_state(ST_BUBBLE);
                    end else if (!in_stall) begin
                        out_pc <= out_pc + PC_WIDTH'(1);
                    end
                end
                ST_BUBBLE: begin
                    if (in_halt) begin
                        state           <= ST_HALT;
                        out_fetch_valid <= is_fetch_state(ST_HALT);
                        out_halted      <= 1'b1;
                    end else begin
                        state           <= ST_RUN;
                        out_fetch_valid <= is_fetch_state(ST_RUN);
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state           <= ST_BOOT;
                    out_fetch_valid <= 1'b0;
                    out_halted      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic
// compared against a behavioural model of the sequencing rules.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_alu_result = '0;
    logic        in_flag_we = 1'b0;
    logic        in_ctrl_take = 1'b0;
    logic [31:0] in_target = '0;
    logic        in_stall = 1'b0;
    logic        in_halt = 1'b0;
    logic [31:0] out_pc;
    logic        out_neg, out_zero, out_fetch_valid, out_redirect, out_halted;

    int checks = 0;
    int errors = 0;

    // Behavioural model
    logic [31:0] m_pc;
    bit m_neg, m_zero, m_redir, m_boot, m_bubble, m_halt;

    pc_sequencer #(.PC_WIDTH(32), .RESET_VECTOR(32'h0)) dut (
        .clk(clk), .rst(rst), .in_alu_result(in_alu_result), .in_flag_we(in_flag_we),
        .in_ctrl_take(in_ctrl_take), .in_target(in_target), .in_stall(in_stall),
        .in_halt(in_halt), .out_pc(out_pc), .out_neg(out_neg), .out_zero(out_zero),
        .out_fetch_valid(out_fetch_valid), .out_redirect(out_redirect), .out_halted(out_halted)
    );

    always #5 clk = ~clk;

    wire [36:0] dut_vec = {out_pc, out_neg, out_zero, out_fetch_valid, out_redirect, out_halted};

    function automatic logic [36:0] exp_vec();
        logic fv;
        fv = !(m_boot || m_bubble || m_halt);
        return {m_pc, m_neg, m_zero, fv, m_redir, m_halt};
    endfunction

    function automatic void model_reset();
        m_pc = 32'h0; m_neg = 0; m_zero = 0; m_redir = 0;
        m_boot = 1; m_bubble = 0; m_halt = 0;
    endfunction

    function automatic void model_step();
        if (!m_halt && in_flag_we) begin
            m_zero = (in_alu_result == 32'h0);
            m_neg  = in_alu_result[31];
        end
        m_redir = 0;
        if (m_halt) begin
        end else if (m_boot) begin
            m_boot = 0;
        end else if (m_bubble) begin
            m_bubble = 0;
            if (in_halt) m_halt = 1;
        end else if (in_halt) begin
            m_halt = 1;
        end else if (in_ctrl_take) begin
            m_pc = in_target; m_redir = 1; m_bubble = 1;
        end else if (!in_stall) begin
            m_pc = m_pc + 32'd1;
        end
    endfunction

    task automatic clear_inputs();
        in_alu_result = '0; in_flag_we = 0; in_ctrl_take = 0;
        in_target = '0; in_stall = 0; in_halt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        model_reset();
        checks++;
        if (dut_vec !== exp_vec() || dut_vec !== 37'h0) begin
            errors++; $display("FAIL reset_state: got %h expected %h", dut_vec, exp_vec());
        end
        do_reset();
        checks++;
        if (out_fetch_valid !== 1'b0 || out_pc !== 32'h0) begin
            errors++; $display("FAIL reset_release_fv: got fv=%b pc=%h expected fv=0 pc=0", out_fetch_valid, out_pc);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_pc !== 32'(i) || out_fetch_valid !== 1'b1 || dut_vec !== exp_vec()) begin
                errors++; $display("FAIL boot_seq[%0d]: got %h expected pc=%0d vec %h", i, dut_vec, i, exp_vec());
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (out_pc !== 32'd5) begin
            errors++; $display("FAIL branch_setup: got pc=%h expected 5", out_pc);
        end
        in_ctrl_take = 1; in_target = 32'h40;
        tick();
        clear_inputs();
        checks++;
        if (out_pc !== 32'h40 || out_redirect !== 1'b1 || out_fetch_valid !== 1'b0 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL branch_redirect: got %h expected pc=40 redir=1 fv=0 (%h)", dut_vec, exp_vec());
        end
        tick();
        checks++;
        if (out_pc !== 32'h40 || out_redirect !== 1'b0 || out_fetch_valid !== 1'b1) begin
            errors++; $display("FAIL branch_first_fetch: got %h expected pc=40 redir=0 fv=1", dut_vec);
        end
        tick();
        checks++;
        if (out_pc !== 32'h41 || out_fetch_valid !== 1'b1) begin
            errors++; $display("FAIL branch_next: got pc=%h fv=%b expected 41 1", out_pc, out_fetch_valid);
        end
    endtask

    task automatic test_flags();
        do_reset();
        tick();
        in_flag_we = 1; in_alu_result = 32'h8000_0000;
        tick();
        checks++;
        if (out_neg !== 1'b1 || out_zero !== 1'b0) begin
            errors++; $display("FAIL flags_neg: got neg=%b zero=%b expected 1 0", out_neg, out_zero);
        end
        in_alu_result = 32'h0;
        tick();
        checks++;
        if (out_neg !== 1'b0 || out_zero !== 1'b1) begin
            errors++; $display("FAIL flags_zero: got neg=%b zero=%b expected 0 1", out_neg, out_zero);
        end
        // branch-if-zero decided on the current (old) flags while a new write lands
        in_alu_result = 32'h8000_0001;
        in_ctrl_take = out_zero; in_target = 32'h10;
        tick();
        clear_inputs();
        checks++;
        if (out_redirect !== 1'b1 || out_pc !== 32'h10 || out_neg !== 1'b1 || out_zero !== 1'b0) begin
            errors++; $display("FAIL flags_take_old: got %h expected pc=10 redir=1 neg=1 zero=0", dut_vec);
        end
        // capture during BUBBLE and during stall
        in_flag_we = 1; in_alu_result = 32'h0;
        tick();
        checks++;
        if (out_zero !== 1'b1 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL flags_bubble: got %h expected %h", dut_vec, exp_vec());
        end
        in_stall = 1; in_alu_result = 32'hFFFF_FFFF;
        tick();
        checks++;
        if (out_neg !== 1'b1 || out_zero !== 1'b0 || out_pc !== 32'h10) begin
            errors++; $display("FAIL flags_stall: got %h expected pc=10 neg=1 zero=0", dut_vec);
        end
        clear_inputs();
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        in_stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_pc !== 32'd7 || out_fetch_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold[%0d]: got pc=%h fv=%b expected 7 1", i, out_pc, out_fetch_valid);
            end
        end
        in_stall = 0;
        tick();
        checks++;
        if (out_pc !== 32'd8) begin
            errors++; $display("FAIL stall_release: got pc=%h expected 8", out_pc);
        end
        in_stall = 1; in_ctrl_take = 1; in_target = 32'h100;
        tick();
        clear_inputs();
        checks++;
        if (out_pc !== 32'h100 || out_redirect !== 1'b1 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL stall_take: got %h expected pc=100 redir=1", dut_vec);
        end
    endtask

    task automatic test_wrap_halt();
        do_reset();
        tick();
        in_ctrl_take = 1; in_target = 32'hFFFF_FFFF;
        tick();
        clear_inputs();
        tick();
        checks++;
        if (out_pc !== 32'hFFFF_FFFF || out_fetch_valid !== 1'b1) begin
            errors++; $display("FAIL wrap_setup: got pc=%h fv=%b expected ffffffff 1", out_pc, out_fetch_valid);
        end
        tick();
        checks++;
        if (out_pc !== 32'h0 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL wrap: got pc=%h expected 0", out_pc);
        end
        in_halt = 1; in_ctrl_take = 1; in_target = 32'h55;
        tick();
        checks++;
        if (out_halted !== 1'b1 || out_pc !== 32'h0 || out_redirect !== 1'b0 || out_fetch_valid !== 1'b0) begin
            errors++; $display("FAIL halt_enter: got %h expected pc=0 halted=1 redir=0 fv=0", dut_vec);
        end
        for (int i = 0; i < 5; i++) begin
            in_halt = 1'($urandom); in_ctrl_take = 1'($urandom); in_stall = 1'($urandom);
            in_target = $urandom; in_flag_we = 1; in_alu_result = (i == 2) ? 32'h0 : 32'h8000_0000;
            tick();
            checks++;
            if (out_halted !== 1'b1 || out_pc !== 32'h0 || out_neg !== 1'b0 || out_zero !== 1'b0 || dut_vec !== exp_vec()) begin
                errors++; $display("FAIL halt_hold[%0d]: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        clear_inputs();
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (out_halted !== 1'b0 || dut_vec !== 37'h0) begin
            errors++; $display("FAIL halt_async_reset: got %h expected 0", dut_vec);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        in_flag_we = 1; in_alu_result = 32'h8000_0000;
        in_ctrl_take = 1; in_target = 32'h30;
        tick();
        clear_inputs();
        checks++;
        if (out_redirect !== 1'b1 || out_neg !== 1'b1) begin
            errors++; $display("FAIL bubble_setup: got %h expected redir=1 neg=1", dut_vec);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (dut_vec !== 37'h0) begin
            errors++; $display("FAIL bubble_async_reset: got %h expected 0", dut_vec);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        tick();
        checks++;
        if (out_pc !== 32'h0 || out_fetch_valid !== 1'b1 || out_redirect !== 1'b0 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL restart: got %h expected pc=0 fv=1", dut_vec);
        end
        tick();
        checks++;
        if (out_pc !== 32'h1) begin
            errors++; $display("FAIL restart_next: got pc=%h expected 1", out_pc);
        end
    endtask

    task automatic test_random();
        int halt_cycles;
        halt_cycles = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            in_halt       = ($urandom_range(0, 39) == 0);
            in_ctrl_take  = ($urandom_range(0, 5) == 0);
            in_stall      = ($urandom_range(0, 3) == 0);
            in_target     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom;
            in_flag_we    = 1'($urandom);
            in_alu_result = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL random[%0d]: got %h expected %h", i, dut_vec, exp_vec());
            end
            if (m_halt) halt_cycles++;
            if (halt_cycles > 3) begin
                halt_cycles = 0;
                do_reset();
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_branch();
        test_flags();
        test_stall();
        test_wrap_halt();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
